cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single Common Data Bus between NUM_SRC result producers (ALU FUs, load-store unit).
//  Each source has a one-entry holding buffer with a valid/ready handshake.
//  A round-robin scheduler picks one buffered result per cycle and drives it onto a registered CDB.
//  Sits between FU/LSU result outputs and the RS/ROB/register-file CDB consumers.
// PARAMETERS
//  NUM_SRC    4   number of result producers (>=2); source NUM_SRC-1 is the load-store unit by convention
//  SRC_W      $clog2(NUM_SRC)   round-robin pointer width (derived, do not override)
//  Widths use codebase macros: `PHYSICAL_REG_NUM_WIDTH, `REG_VAL_WIDTH, `ROB_SIZE_WIDTH
// PORTS
//  clk                 in   1                          clock, all state on rising edge
//  reset               in   1                          asynchronous, active-low reset (0 = reset)
//  flush               in   1                          sync squash: drop all buffered and in-flight results
//  src_valid           in   NUM_SRC                    source i presents a result
//  src_ready           out  NUM_SRC                    holding buffer i can accept this cycle
//  src_register_addr   in   [NUM_SRC][PHYS_REG_W]      destination physical register per source
//  src_register_val    in   [NUM_SRC][REG_VAL_W]       result value per source
//  src_inst_tag        in   [NUM_SRC][ROB_SIZE_W]      ROB tag per source
//  cdb_valid           out  1                          registered CDB broadcast valid
//  cdb_register_addr   out  PHYS_REG_W                 broadcast destination register
//  cdb_register_val    out  REG_VAL_W                  broadcast value
//  cdb_inst_tag        out  ROB_SIZE_W                 broadcast ROB tag
//  cdb_src_id          out  SRC_W                      index of source that won this broadcast
// BEHAVIOUR
//  Reset (reset=0, async): hold_valid=0 for all i, rr_ptr=0, cdb_valid=0, cdb_register_addr/val/inst_tag=0, cdb_src_id=0.
//  Holding buffer i: hold_valid[i], hold_addr/val/tag[i].
//  src_ready[i] = !hold_valid[i] | grant[i] (combinational). The same-cycle grant frees the slot, so there is no bubble.
//  Accept: src_valid[i] & src_ready[i] & !flush -> buffer i loads payload at next edge, hold_valid[i]=1.
//  src_valid with src_ready=0: source holds its payload stable; the arbiter does not sample it.
//  Arbitration (comb, every cycle): scan hold_valid from rr_ptr upward, modulo NUM_SRC. The first set bit wins and asserts grant[w] (one-hot or zero).
//  On a grant at edge: cdb_* <= hold_*[w], cdb_valid<=1, cdb_src_id<=w, rr_ptr <= (w+1) mod NUM_SRC.
//  On the same edge, hold_valid[w] clears unless refilled by a simultaneous accept, in which case it stays 1 with the new payload.
//  No grant: cdb_valid<=0. cdb_* data keeps its old value; consumers qualify data with cdb_valid only.
//  rr_ptr changes only on a grant. Wrap: w=NUM_SRC-1 gives rr_ptr=0.
//  Latency: src handshake at edge N -> earliest cdb_valid after edge N+1 (2 edges). An uncontended source can issue every cycle.
//  Throughput: exactly one broadcast per cycle while any hold_valid=1.
//  Fairness: a continuously requesting source waits at most NUM_SRC-1 grants.
//  flush=1: at the next edge all hold_valid<=0 and cdb_valid<=0. Accepts and grants in that cycle are discarded and rr_ptr is unchanged. src_ready stays per the formula; the handshake is lost by design.
//  Reset mid-operation: all buffered results are discarded immediately and the outputs take their reset values.
//  Buffers are not visible outside this block; cdb_valid is never asserted for a slot that was flushed.
// TESTING
//  1. Reset: drive reset=0 async mid-cycle with all buffers full -> cdb_valid=0, src_ready=4'b1111 immediately, rr_ptr=0.
//  2. Single source: src_valid[2]=1 for one cycle, addr=7, val=32'hDEAD_BEEF, tag=3 -> cdb_valid=1 two edges later with addr=7, val=DEADBEEF, tag=3, src_id=2.
//  3. All 4 valid at once, rr_ptr=0 -> broadcasts src 0,1,2,3 on 4 consecutive cycles, then cdb_valid=0.
//  4. Source 3 streams every cycle, source 1 requests once -> src 1 is granted within 2 cycles and src 3 gets the following slot.
//  5. Source 0 streams back-to-back with no contention -> src_ready[0] stays 1 and cdb_valid is 1 every cycle with consecutive payloads.
//  6. Flush with buffers 0 and 2 full and src_valid[1]=1 in the same cycle -> no cdb_valid on the next 2 cycles, src_ready=1111, rr_ptr unchanged.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-entry holding buffer per result producer, a
// round-robin pick of one buffered result per cycle, and a registered CDB.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif

module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            flush,
  // Handshake: a result transfers on a rising edge where src_valid[i] and
  // src_ready[i] are both 1 and flush is 0; a source seeing src_ready[i]=0
  // keeps its payload stable until the transfer happens.
  input  logic [NUM_SRC-1:0]                              src_valid,
  output logic [NUM_SRC-1:0]                              src_ready,
  input  logic [NUM_SRC-1:0][`PHYSICAL_REG_NUM_WIDTH-1:0] src_register_addr,
  input  logic [NUM_SRC-1:0][`REG_VAL_WIDTH-1:0]          src_register_val,
  input  logic [NUM_SRC-1:0][`ROB_SIZE_WIDTH-1:0]         src_inst_tag,
  output logic                                            cdb_valid,
  output logic [`PHYSICAL_REG_NUM_WIDTH-1:0]              cdb_register_addr,
  output logic [`REG_VAL_WIDTH-1:0]                       cdb_register_val,
  output logic [`ROB_SIZE_WIDTH-1:0]                      cdb_inst_tag,
  output logic [SRC_W-1:0]                                cdb_src_id
);

  logic [NUM_SRC-1:0]                              hold_valid;
  logic [NUM_SRC-1:0][`PHYSICAL_REG_NUM_WIDTH-1:0] hold_addr;
  logic [NUM_SRC-1:0][`REG_VAL_WIDTH-1:0]          hold_val;
  logic [NUM_SRC-1:0][`ROB_SIZE_WIDTH-1:0]         hold_tag;
  logic [SRC_W-1:0]                                rr_ptr;

  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] accept;
  logic [SRC_W-1:0]   win;
  logic [SRC_W-1:0]   rr_next;
  logic               any_grant;

  // Scan hold_valid starting at rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    grant     = '0;
    win       = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!any_grant && hold_valid[idx]) begin
        any_grant = 1'b1;
        win       = SRC_W'(idx);
      end
    end
    if (any_grant) grant[win] = 1'b1;
  end

  assign rr_next   = (win == SRC_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;
  // A slot being granted this cycle can be refilled on the same edge.
  assign src_ready = ~hold_valid | grant;
  assign accept    = src_valid & src_ready & {NUM_SRC{~flush}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid        <= '0;
      hold_addr         <= '0;
      hold_val          <= '0;
      hold_tag          <= '0;
      rr_ptr            <= '0;
      cdb_valid         <= 1'b0;
      cdb_register_addr <= '0;
      cdb_register_val  <= '0;
      cdb_inst_tag      <= '0;
      cdb_src_id        <= '0;
    end else if (flush) begin
      hold_valid <= '0;
      cdb_valid  <= 1'b0;
    end else begin
      cdb_valid <= any_grant;
      if (any_grant) begin
        cdb_register_addr <= hold_addr[win];
        cdb_register_val  <= hold_val[win];
        cdb_inst_tag      <= hold_tag[win];
        cdb_src_id        <= win;
        rr_ptr            <= rr_next;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i]) begin
          hold_valid[i] <= 1'b1;
          hold_addr[i]  <= src_register_addr[i];
          hold_val[i]   <= src_register_val[i];
          hold_tag[i]   <= src_inst_tag[i];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule
